aurora_simplex_tx_ctrl: RTL
===========================

Name: aurora_simplex_tx_ctrl

Overview:
- Sequences the Aurora 64B/66B simplex TX channel through reset, alignment, bonding, verification and ready.
- Selects the block type each lane encoder emits and schedules clock-compensation (CC) insertion.
- Gates the AXI-Stream user interface and derives lane enables from the single-lane configuration.
- Sits between the RX sideband status inputs (simplex_*) and the per-lane encoder/scrambler datapath in aurora_top.

Parameters:
MAX_LINKS, 4, number of physical lanes
LANE_SEL_W, 2, width of lane_select (clog2(MAX_LINKS))
RESET_CYCLES, 64, cycles held in RESET before ALIGN
TIMEOUT, 65536, max cycles in ALIGN/BOND/VERIFY without progress
CC_PERIOD, 5000, cycles between CC sequence starts
CC_LEN, 3, CC blocks per sequence

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
single_lane  in  1  1 = single-lane mode, BOND skipped
lane_select  in  LANE_SEL_W  active lane index in single-lane mode
simplex_aligned  in  1  sideband: RX aligned
simplex_bonded  in  1  sideband: RX lanes bonded
simplex_verified  in  1  sideband: RX verified
simplex_reset  in  1  sideband: RX requests channel reset
axi_valid  in  1  user data valid
axi_ready  out  1  user data accepted when high with axi_valid
lane_en  out  MAX_LINKS  per-lane enable to encoders
blk_sel  out  3  0 NONE, 1 IDLE, 2 CB, 3 VER, 4 CC, 5 DATA
channel_up  out  1  high in READY
timeout_err  out  1  one-cycle pulse on init timeout
cfg_err  out  1  sticky: lane_select >= MAX_LINKS latched

Behaviour:
- One clock, one reset. Reset is asynchronous and active-high; all flops clear on rst.
- All outputs are registered; a response appears one cycle after the input is sampled.
- Reset values: state=RESET, blk_sel=0, axi_ready=0, channel_up=0, lane_en=0, timeout_err=0, cfg_err=0, all counters 0.
- Sideband inputs are synchronous to clk.
- States and block types:
  - RESET: blk_sel=NONE, lane_en=0. Counts RESET_CYCLES, then latches single_lane and lane_select and moves to ALIGN.
  - ALIGN: blk_sel=IDLE. On simplex_aligned, goes to VERIFY if latched single_lane, else BOND.
  - BOND: blk_sel=CB. On simplex_bonded, goes to VERIFY.
  - VERIFY: blk_sel=VER. On simplex_verified, goes to READY.
  - READY: channel_up=1, axi_ready=1 except during CC. blk_sel=DATA when axi_valid&axi_ready, else IDLE.
- Lane enables: latched single_lane=1 gives lane_en=onehot(latched lane_select). If lane_select>=MAX_LINKS, lane 0 is used and cfg_err sets; cfg_err clears only on rst. single_lane=0 gives lane_en all ones.
- Configuration inputs are ignored outside the RESET exit cycle.
- Priority each cycle, highest first:
  1. simplex_reset: next state RESET from any state, counters cleared.
  2. READY with simplex_aligned=0: next state RESET.
  3. Timeout: state-cycle counter reaches TIMEOUT-1 in ALIGN/BOND/VERIFY without the awaited input; next state RESET, timeout_err pulses 1 cycle.
  4. Normal transitions as listed above.
- State-cycle counter resets on every state change.
- CC scheduler:
  - Free-running counter, held at 0 in RESET, runs in all other states. Wraps at CC_PERIOD-1.
  - At wrap, a CC sequence starts the next cycle: blk_sel=CC for CC_LEN consecutive cycles, overriding IDLE/CB/VER/DATA.
  - axi_ready=0 during CC; the counter keeps running.
  - A CC sequence in progress completes even if the state changes, except on entry to RESET, which aborts it.
  - The state-cycle counter runs during CC; CC cycles count toward TIMEOUT.
- An awaited input arriving during CC takes effect normally; blk_sel returns to the new state's type after CC ends.
- axi_last has no effect on this block; frame boundaries are not tracked.

Test Plan:
RESET_CYCLES=8, CC_PERIOD=16, CC_LEN=3, TIMEOUT=64, MAX_LINKS=4.
1. rst pulse, single_lane=1, lane_select=2, aligned at cycle 13, verified at cycle 18 -> RESET 8 cycles, lane_en=4'b0100, VERIFY entered (BOND skipped), channel_up=1 from cycle 19.
2. single_lane=0, aligned, then bonded 5 cycles later, then verified -> states ALIGN->BOND->VERIFY->READY, lane_en=4'b1111, blk_sel IDLE->CB->VER.
3. READY with axi_valid=1 continuously -> blk_sel=CC and axi_ready=0 for exactly 3 cycles every 16 cycles, DATA otherwise.
4. Hold simplex_aligned=0 in ALIGN -> after 64 cycles timeout_err pulses once, state RESET, then ALIGN again 8 cycles later.
5. simplex_reset asserted mid-CC in READY -> next cycle RESET, blk_sel=NONE, channel_up=0, axi_ready=0; also drop simplex_aligned in READY -> RESET.
6. single_lane=1, lane_select=3 -> lane_en=4'b1000, cfg_err=0; with LANE_SEL_W=3, lane_select=5 -> lane_en=4'b0001, cfg_err=1 until rst.

Source files
------------

// File: rtl/aurora_simplex_tx_ctrl.sv
// Aurora 64B/66B simplex TX channel control: init sequencing, block-type select, CC scheduling, lane enables.
// Outputs are registered one cycle after their inputs; axi_ready drops during CC and outside READY.
module aurora_simplex_tx_ctrl #(
  parameter int MAX_LINKS    = 4,
  parameter int LANE_SEL_W   = 2,
  parameter int RESET_CYCLES = 64,
  parameter int TIMEOUT      = 65536,
  parameter int CC_PERIOD    = 5000,
  parameter int CC_LEN       = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  single_lane,
  input  logic [LANE_SEL_W-1:0] lane_select,
  input  logic                  simplex_aligned,
  input  logic                  simplex_bonded,
  input  logic                  simplex_verified,
  input  logic                  simplex_reset,
  input  logic                  axi_valid,
  output logic                  axi_ready,
  output logic [MAX_LINKS-1:0]  lane_en,
  output logic [2:0]            blk_sel,
  output logic                  channel_up,
  output logic                  timeout_err,
  output logic                  cfg_err
);
  typedef enum logic [2:0] {ST_RESET, ST_ALIGN, ST_BOND, ST_VERIFY, ST_READY} state_t;

  localparam logic [2:0] BLK_NONE = 3'd0, BLK_IDLE = 3'd1, BLK_CB = 3'd2,
                         BLK_VER  = 3'd3, BLK_CC   = 3'd4, BLK_DATA = 3'd5;
  localparam int SCW  = $clog2((TIMEOUT > RESET_CYCLES ? TIMEOUT : RESET_CYCLES) + 1);
  localparam int CCW  = $clog2(CC_PERIOD + 1);
  localparam int REMW = $clog2(CC_LEN + 1);

  state_t               state, state_nxt;
  logic [SCW-1:0]       st_cnt;
  logic [CCW-1:0]       cc_cnt, cc_cnt_nxt;
  logic [REMW-1:0]      cc_rem, cc_rem_nxt;
  logic                 single_q;
  logic                 tmo_hit, cc_wrap, cc_nxt, cfg_bad;
  logic [MAX_LINKS-1:0] cfg_lanes;

  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    if (simplex_reset) begin
      state_nxt = ST_RESET;
    end else begin
      case (state)
        ST_RESET:  if (st_cnt == SCW'(RESET_CYCLES - 1)) state_nxt = ST_ALIGN;
        ST_ALIGN:  if (simplex_aligned) state_nxt = single_q ? ST_VERIFY : ST_BOND;
                   else if (st_cnt == SCW'(TIMEOUT - 1)) begin state_nxt = ST_RESET; tmo_hit = 1'b1; end
        ST_BOND:   if (simplex_bonded) state_nxt = ST_VERIFY;
                   else if (st_cnt == SCW'(TIMEOUT - 1)) begin state_nxt = ST_RESET; tmo_hit = 1'b1; end
        ST_VERIFY: if (simplex_verified) state_nxt = ST_READY;
                   else if (st_cnt == SCW'(TIMEOUT - 1)) begin state_nxt = ST_RESET; tmo_hit = 1'b1; end
        ST_READY:  if (!simplex_aligned) state_nxt = ST_RESET;
        default:   state_nxt = ST_RESET;
      endcase
    end
  end

  // CC counter idles at 0 in RESET; a sequence starts the cycle after each wrap and dies on RESET entry.
  always_comb begin
    cc_wrap    = (state != ST_RESET) && (cc_cnt == CCW'(CC_PERIOD - 1));
    cc_cnt_nxt = (state == ST_RESET || state_nxt == ST_RESET || cc_wrap) ? '0 : cc_cnt + CCW'(1);
    if (state_nxt == ST_RESET)  cc_rem_nxt = '0;
    else if (cc_wrap)           cc_rem_nxt = REMW'(CC_LEN);
    else if (cc_rem != '0)      cc_rem_nxt = cc_rem - REMW'(1);
    else                        cc_rem_nxt = '0;
    cc_nxt    = (cc_rem_nxt != '0);
    cfg_bad   = single_lane && (int'(lane_select) >= MAX_LINKS);
    cfg_lanes = !single_lane ? '1 : cfg_bad ? MAX_LINKS'(1) : MAX_LINKS'(1) << lane_select;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RESET;
      st_cnt      <= '0;
      cc_cnt      <= '0;
      cc_rem      <= '0;
      single_q    <= 1'b0;
      lane_en     <= '0;
      blk_sel     <= BLK_NONE;
      axi_ready   <= 1'b0;
      channel_up  <= 1'b0;
      timeout_err <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      st_cnt      <= (state_nxt != state || simplex_reset) ? '0 : st_cnt + SCW'(1);
      cc_cnt      <= cc_cnt_nxt;
      cc_rem      <= cc_rem_nxt;
      timeout_err <= tmo_hit;
      channel_up  <= (state_nxt == ST_READY);
      axi_ready   <= (state_nxt == ST_READY) && !cc_nxt;
      if (state == ST_RESET && state_nxt == ST_ALIGN) begin
        single_q <= single_lane;
        lane_en  <= cfg_lanes;
        if (cfg_bad) cfg_err <= 1'b1;
      end else if (state_nxt == ST_RESET) begin
        lane_en <= '0;
      end
      // DATA marks the beat offered now, which is accepted if ready is high next cycle.
      if (cc_nxt) blk_sel <= BLK_CC;
      else begin
        case (state_nxt)
          ST_ALIGN:  blk_sel <= BLK_IDLE;
          ST_BOND:   blk_sel <= BLK_CB;
          ST_VERIFY: blk_sel <= BLK_VER;
          ST_READY:  blk_sel <= axi_valid ? BLK_DATA : BLK_IDLE;
          default:   blk_sel <= BLK_NONE;
        endcase
      end
    end
  end
endmodule
